// File: rtl/race_pkg.sv
// Shared definitions for the RACE filter front end: default widths, MAC timing
// and the tap sequencer state encoding.
package race_pkg;

   localparam int SAMPLE_SIZE_D = 16;
   localparam int COEFF_SIZE_D  = 17;
   localparam int ACC_W         = SAMPLE_SIZE_D + COEFF_SIZE_D;

   // Multiplier register followed by accumulator register; the two drain states cover it.
   localparam int MAC_LATENCY   = 2;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN1,
      DRAIN2,
      CAPTURE
   } seq_state_t;

endpackage

// File: rtl/tap_ram.sv
// DEPTH x W register file: synchronous write, combinational read, cleared on reset.
// Used for both the sample delay line and the coefficient file.
module tap_ram #(
   parameter int DEPTH = 32,
   parameter int W     = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [DEPTH-1:0][W-1:0] mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mem <= '0;
      else if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Streams TAPS (sample, coefficient) pairs per accepted sample into the MAC and
// turns the free-running MAC accumulator into per-frame results by differencing.
module fir_tap_sequencer
   import race_pkg::*;
#(
   parameter int SAMPLE_SIZE = SAMPLE_SIZE_D,
   parameter int COEFF_SIZE  = COEFF_SIZE_D,
   parameter int TAPS        = 32,
   localparam int AW         = $clog2(TAPS),
   localparam int YW         = SAMPLE_SIZE + COEFF_SIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [SAMPLE_SIZE-1:0] s_data,
   input  logic                   c_we,
   input  logic [AW-1:0]          c_addr,
   input  logic [COEFF_SIZE-1:0]  c_wdata,
   output logic                   busy,
   output logic                   mac_en,
   output logic [SAMPLE_SIZE-1:0] mac_s,
   output logic [COEFF_SIZE-1:0]  mac_c,
   input  logic [YW-1:0]          acc_in,
   output logic                   y_valid,
   output logic [YW-1:0]          y_data
);

   seq_state_t state, state_nx;

   logic [AW-1:0]          head;
   logic [AW-1:0]          k;
   logic [YW-1:0]          prev;
   logic                   accept;
   logic                   coef_we;
   logic [SAMPLE_SIZE-1:0] samp_rd;
   logic [COEFF_SIZE-1:0]  coef_rd;

   assign s_ready = (state == IDLE);
   assign accept  = s_valid && (state == IDLE);
   assign coef_we = c_we && (state == IDLE);

   // New sample lands one slot ahead of head; reads walk backwards from the new head.
   tap_ram #(.DEPTH(TAPS), .W(SAMPLE_SIZE), .AW(AW)) u_samp (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (head + 1'b1),
      .wdata (s_data),
      .raddr (head - k),
      .rdata (samp_rd)
   );

   // k is 0 in IDLE, so the same read port supplies coef[0] at accept time.
   tap_ram #(.DEPTH(TAPS), .W(COEFF_SIZE), .AW(AW)) u_coef (
      .clk   (clk),
      .rst   (rst),
      .we    (coef_we),
      .waddr (c_addr),
      .wdata (c_wdata),
      .raddr (k),
      .rdata (coef_rd)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (k == AW'(TAPS - 1)) state_nx = DRAIN1;
         DRAIN1:  state_nx = DRAIN2;
         DRAIN2:  state_nx = CAPTURE;
         CAPTURE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         head    <= '0;
         k       <= '0;
         prev    <= '0;
         busy    <= 1'b0;
         mac_en  <= 1'b0;
         mac_s   <= '0;
         mac_c   <= '0;
         y_valid <= 1'b0;
         y_data  <= '0;
      end else begin
         state   <= state_nx;
         busy    <= (state_nx != IDLE);
         mac_en  <= 1'b0;
         y_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  // Tap 0 is forwarded straight from the input; the RAM write lands this edge.
                  head   <= head + 1'b1;
                  mac_s  <= s_data;
                  mac_c  <= coef_rd;
                  mac_en <= 1'b1;
                  k      <= AW'(1);
               end
            end
            RUN: begin
               mac_s  <= samp_rd;
               mac_c  <= coef_rd;
               mac_en <= 1'b1;
               k      <= k + 1'b1;   // wraps back to 0 after the last tap
            end
            CAPTURE: begin
               // Modular difference; accumulator wrap cancels out.
               y_data  <= acc_in - prev;
               prev    <= acc_in;
               y_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
